// File: rtl/seq_divider.sv
// Sequential restoring shift-subtract divider with start/done handshake.
// One quotient bit is produced per clock; an n-bit divide takes n CALC cycles.
module seq_divider #(
    parameter int unsigned n = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [n-1:0] Dividend,
    input  logic [n-1:0] Divisor,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero,
    output logic [n-1:0] Quotient,
    output logic [n-1:0] Remainder
);

    localparam int unsigned CW = $clog2(n + 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e        state_q, state_d;
    // A always stays below D, so its top bit would be constant zero and is not stored.
    logic [n-1:0]  a_q, a_d;
    logic [n-1:0]  q_q, q_d;
    logic [n-1:0]  d_q, d_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [n-1:0]  quo_q, quo_d;
    logic [n-1:0]  rem_q, rem_d;
    logic          dbz_q, dbz_d;
    logic [n:0]    shifted;
    logic [n:0]    trial;

    // Shift {A,Q} left by one and form the trial subtraction at n+1 bits.
    always_comb begin
        shifted = {a_q, q_q[n-1]};
        trial   = shifted - {1'b0, d_q};
    end

    // Controller and datapath next-state; output registers load only on entry to DONE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d   = '0;
                    q_d   = Dividend;
                    d_d   = Divisor;
                    cnt_d = CW'(n);
                    dbz_d = 1'b0;
                    if (Divisor == '0) begin
                        // Skip the iterations entirely and report the fixed result.
                        state_d = StDone;
                        quo_d   = '1;
                        rem_d   = Dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                if (!trial[n]) begin
                    a_d = trial[n-1:0];
                    q_d = {q_q[n-2:0], 1'b1};
                end else begin
                    // Restore: keep the shifted partial remainder.
                    a_d = shifted[n-1:0];
                    q_d = {q_q[n-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = StDone;
                    quo_d   = q_d;
                    rem_d   = a_d;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    // Status and result outputs decoded straight from registered state.
    always_comb begin
        busy        = (state_q == StCalc);
        done        = (state_q == StDone);
        div_by_zero = dbz_q;
        Quotient    = quo_q;
        Remainder   = rem_q;
    end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: a 4-bit and an 8-bit instance share one stimulus stream.
// The 4-bit instance sees the low nibble of each operand.
module tb_seq_divider;

    localparam int unsigned N4 = 4;
    localparam int unsigned N8 = 8;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] q4;
        logic [3:0] r4;
        logic       dz4;
        logic [7:0] q8;
        logic [7:0] r8;
        logic       dz8;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [7:0] divisor = '0;

    logic       busy4, done4, dbz4;
    logic [3:0] quo4, rem4;
    logic       busy8, done8, dbz8;
    logic [7:0] quo8, rem8;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    seq_divider #(.n(N4)) u_dut4 (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .Dividend    (dividend[3:0]),
        .Divisor     (divisor[3:0]),
        .busy        (busy4),
        .done        (done4),
        .div_by_zero (dbz4),
        .Quotient    (quo4),
        .Remainder   (rem4)
    );

    seq_divider #(.n(N8)) u_dut8 (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .Dividend    (dividend),
        .Divisor     (divisor),
        .busy        (busy8),
        .done        (done8),
        .div_by_zero (dbz8),
        .Quotient    (quo8),
        .Remainder   (rem8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division; divide by zero yields all ones and the dividend.
    function automatic vec_t model(input logic [7:0] a, input logic [7:0] b);
        vec_t v;
        v.a = a;
        v.b = b;
        if (b[3:0] == 4'd0) begin
            v.q4 = 4'hF;
            v.r4 = a[3:0];
            v.dz4 = 1'b1;
        end else begin
            v.q4 = a[3:0] / b[3:0];
            v.r4 = a[3:0] % b[3:0];
            v.dz4 = 1'b0;
        end
        if (b == 8'd0) begin
            v.q8 = 8'hFF;
            v.r8 = a;
            v.dz8 = 1'b1;
        end else begin
            v.q8 = a / b;
            v.r8 = a % b;
            v.dz8 = 1'b0;
        end
        return v;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, ".busy4"}, 32'(busy4), 32'd0);
        check({tag, ".done4"}, 32'(done4), 32'd0);
        check({tag, ".dbz4"},  32'(dbz4),  32'd0);
        check({tag, ".quo4"},  32'(quo4),  32'd0);
        check({tag, ".rem4"},  32'(rem4),  32'd0);
        check({tag, ".busy8"}, 32'(busy8), 32'd0);
        check({tag, ".done8"}, 32'(done8), 32'd0);
        check({tag, ".dbz8"},  32'(dbz8),  32'd0);
        check({tag, ".quo8"},  32'(quo8),  32'd0);
        check({tag, ".rem8"},  32'(rem8),  32'd0);
    endtask

    // One operation on both instances. Cycle c counts from the cycle after the accepting
    // edge. If inject_at > 0, a 6/3 start is pulsed in that cycle and must be ignored.
    task automatic run_op(input vec_t v, input int inject_at, input string tag);
        int lat4, lat8, d4, d8, b4, b8;
        lat4 = v.dz4 ? 1 : N4 + 1;
        lat8 = v.dz8 ? 1 : N8 + 1;
        d4 = 0; d8 = 0; b4 = 0; b8 = 0;
        @(negedge clock);
        dividend = v.a;
        divisor  = v.b;
        start    = 1'b1;
        for (int c = 1; c <= int'(N8) + 3; c++) begin
            @(negedge clock);
            start = 1'b0;
            if (c == 1) begin
                dividend = 8'($urandom);
                divisor  = 8'($urandom);
            end
            if (c == inject_at) begin
                dividend = 8'd6;
                divisor  = 8'd3;
                start    = 1'b1;
            end
            if (busy4) b4++;
            if (busy8) b8++;
            if (done4) begin
                d4++;
                check({tag, ".lat4"}, 32'(c), 32'(lat4));
                check({tag, ".q4"},   32'(quo4), 32'(v.q4));
                check({tag, ".r4"},   32'(rem4), 32'(v.r4));
                check({tag, ".dz4"},  32'(dbz4), 32'(v.dz4));
            end
            if (done8) begin
                d8++;
                check({tag, ".lat8"}, 32'(c), 32'(lat8));
                check({tag, ".q8"},   32'(quo8), 32'(v.q8));
                check({tag, ".r8"},   32'(rem8), 32'(v.r8));
                check({tag, ".dz8"},  32'(dbz8), 32'(v.dz8));
            end
        end
        check({tag, ".ndone4"}, 32'(d4), 32'd1);
        check({tag, ".ndone8"}, 32'(d8), 32'd1);
        check({tag, ".busy4cyc"}, 32'(b4), v.dz4 ? 32'd0 : 32'(N4));
        check({tag, ".busy8cyc"}, 32'(b8), v.dz8 ? 32'd0 : 32'(N8));
        // Results must still hold once both instances are back in IDLE.
        check({tag, ".hold_q4"}, 32'(quo4), 32'(v.q4));
        check({tag, ".hold_r4"}, 32'(rem4), 32'(v.r4));
        check({tag, ".hold_dz4"}, 32'(dbz4), 32'(v.dz4));
        check({tag, ".hold_q8"}, 32'(quo8), 32'(v.q8));
        check({tag, ".hold_r8"}, 32'(rem8), 32'(v.r8));
        check({tag, ".hold_dz8"}, 32'(dbz8), 32'(v.dz8));
    endtask

    initial begin
        vec_t tbl[$];
        vec_t v;
        logic [7:0] ra, rb;
        int nd;

        // Hand-computed vectors: {a, b, q4, r4, dz4, q8, r8, dz8}.
        tbl.push_back('{8'd13,  8'd4,   4'd3,  4'd1,  1'b0, 8'd3,   8'd1,   1'b0});
        tbl.push_back('{8'd15,  8'd1,   4'd15, 4'd0,  1'b0, 8'd15,  8'd0,   1'b0});
        tbl.push_back('{8'd7,   8'd9,   4'd0,  4'd7,  1'b0, 8'd0,   8'd7,   1'b0});
        tbl.push_back('{8'd0,   8'd5,   4'd0,  4'd0,  1'b0, 8'd0,   8'd0,   1'b0});
        tbl.push_back('{8'd15,  8'd15,  4'd1,  4'd0,  1'b0, 8'd1,   8'd0,   1'b0});
        tbl.push_back('{8'd9,   8'd0,   4'hF,  4'd9,  1'b1, 8'hFF,  8'd9,   1'b1});
        tbl.push_back('{8'd255, 8'd1,   4'd15, 4'd0,  1'b0, 8'd255, 8'd0,   1'b0});
        tbl.push_back('{8'd255, 8'd255, 4'd1,  4'd0,  1'b0, 8'd1,   8'd0,   1'b0});
        tbl.push_back('{8'd200, 8'd7,   4'd1,  4'd1,  1'b0, 8'd28,  8'd4,   1'b0});
        tbl.push_back('{8'd0,   8'd0,   4'hF,  4'd0,  1'b1, 8'hFF,  8'd0,   1'b1});
        tbl.push_back('{8'd255, 8'd0,   4'hF,  4'hF,  1'b1, 8'hFF,  8'hFF,  1'b1});
        tbl.push_back('{8'd6,   8'd3,   4'd2,  4'd0,  1'b0, 8'd2,   8'd0,   1'b0});

        #1 reset = 1'b0;
        #2 check_zero("reset");
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            run_op(tbl[i], 0, $sformatf("vec%0d", i));
        end

        // Start pulsed during CALC is ignored; a later start in IDLE is accepted.
        run_op(tbl[0], 2, "ignore");
        run_op(tbl[11], 0, "restart");

        // Reset two CALC cycles into 13/4: outputs clear at once and no done follows.
        @(negedge clock);
        dividend = 8'd13;
        divisor  = 8'd4;
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1 check_zero("abort");
        nd = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            if (done4 || done8 || busy4 || busy8) nd++;
            if (c == 5) reset = 1'b1;
        end
        check("abort.no_done", 32'(nd), 32'd0);
        check("abort.q8", 32'(quo8), 32'd0);
        run_op(model(8'd10, 8'd3), 0, "after_abort");

        // Randomized operands against the reference model.
        for (int i = 0; i < 400; i++) begin
            ra = 8'($urandom);
            rb = (i % 16 == 0) ? 8'd0 : 8'($urandom);
            v  = model(ra, rb);
            run_op(v, 0, $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
